// File: rtl/ifetch_ctrl_if.sv
// Datapath and instruction-memory signals of the instruction fetch controller.
// The controller takes the slave view; the datapath/memory side takes the master view.
interface ifetch_ctrl_if;
    logic        start;
    logic [63:0] pc;
    logic        busy;
    logic        done;
    logic [79:0] instr;
    logic [3:0]  ilen;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_error;
    logic        instr_error;

    modport slave (
        input  start, pc, mem_ack, mem_rdata,
        output busy, done, instr, ilen, mem_req, mem_addr, mem_error, instr_error
    );

    modport master (
        output start, pc, mem_ack, mem_rdata,
        input  busy, done, instr, ilen, mem_req, mem_addr, mem_error, instr_error
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Byte-serial instruction fetch: reads up to 10 bytes from instruction memory,
// decodes the length from the first byte and assembles the instruction MSB-first.
module ifetch_ctrl #(
    parameter logic [63:0] IMEM_LIMIT = 64'd1023
) (
    input  logic         clk,
    input  logic         rst_n,
    ifetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] base_q, base_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [79:0] instr_q, instr_d;
    logic [3:0]  ilen_q, ilen_d;
    logic        mem_error_q, mem_error_d;
    logic        instr_error_q, instr_error_d;

    logic [63:0] fetch_addr;
    logic [63:0] next_addr;
    logic [3:0]  dec_len;
    logic [3:0]  len_now;

    // Length in bytes for an icode; 0 marks an invalid icode.
    function automatic logic [3:0] decode_len(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       decode_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: decode_len = 4'd2;
            4'h7, 4'h8:             decode_len = 4'd9;
            4'h3, 4'h4, 4'h5:       decode_len = 4'd10;
            default:                decode_len = 4'd0;
        endcase
    endfunction

    assign fetch_addr = base_q + {60'd0, cnt_q};
    assign next_addr  = fetch_addr + 64'd1;
    assign dec_len    = decode_len(bus.mem_rdata[7:4]);
    assign len_now    = (cnt_q == 4'd0) ? dec_len : ilen_q;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        cnt_d         = cnt_q;
        instr_d       = instr_q;
        ilen_d        = ilen_q;
        mem_error_d   = mem_error_q;
        instr_error_d = instr_error_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d        = bus.pc;
                    cnt_d         = '0;
                    instr_d       = '0;
                    ilen_d        = '0;
                    instr_error_d = 1'b0;
                    if (bus.pc > IMEM_LIMIT) begin
                        mem_error_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mem_error_d = 1'b0;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    for (int unsigned k = 0; k < 10; k++) begin
                        if (cnt_q == 4'(k)) instr_d[79 - 8*k -: 8] = bus.mem_rdata;
                    end
                    if (cnt_q == 4'd0 && dec_len == 4'd0) begin
                        instr_error_d = 1'b1;
                        ilen_d        = 4'd1;
                        state_d       = DONE;
                    end else begin
                        ilen_d = len_now;
                        if (cnt_q + 4'd1 == len_now) begin
                            state_d = DONE;
                        end else if (next_addr > IMEM_LIMIT) begin
                            mem_error_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            instr_q       <= '0;
            ilen_q        <= '0;
            mem_error_q   <= 1'b0;
            instr_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            cnt_q         <= cnt_d;
            instr_q       <= instr_d;
            ilen_q        <= ilen_d;
            mem_error_q   <= mem_error_d;
            instr_error_q <= instr_error_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.mem_req     = (state_q == FETCH);
    assign bus.mem_addr    = (state_q == FETCH) ? fetch_addr : '0;
    assign bus.instr       = instr_q;
    assign bus.ilen        = ilen_q;
    assign bus.mem_error   = mem_error_q;
    assign bus.instr_error = instr_error_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed plus randomized bench for ifetch_ctrl against a byte-array memory model
// that derives expected results from the instruction length table.
module tb_ifetch_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ifetch_ctrl_if bus();

    ifetch_ctrl #(.IMEM_LIMIT(64'd1023)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] tmem [0:1023];
    int         mode       = 0;
    int         wait_left  = 0;
    logic       stray      = 1'b0;
    logic [7:0] stray_data = 8'h00;
    logic       ack_w;
    int         done_pulses = 0;

    logic [79:0] last_ei;
    logic [3:0]  last_el;

    typedef struct packed {
        logic [63:0] addr;
        logic        ack;
    } ent_t;
    ent_t log_q[$];

    // Memory responder: mode 0 zero-wait, 1 two wait cycles, 2 random 0..3.
    assign ack_w         = bus.mem_req && (wait_left == 0);
    assign bus.mem_ack   = ack_w | stray;
    assign bus.mem_rdata = ack_w ? tmem[bus.mem_addr[9:0]] : stray_data;

    function automatic int pick_delay();
        if (mode == 0) return 0;
        if (mode == 1) return 2;
        return int'($urandom_range(0, 3));
    endfunction

    always @(posedge clk) begin
        if (!bus.mem_req || ack_w) wait_left <= pick_delay();
        else                       wait_left <= wait_left - 1;
    end

    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) log_q.push_back('{bus.mem_addr, ack_w});
        if (bus.done === 1'b1) done_pulses <= done_pulses + 1;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] len_of(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       return 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd0;
        endcase
    endfunction

    // Bytes fetched = min(length, bytes left before the limit).
    task automatic model(input logic [63:0] pc, output logic [79:0] ei, output logic [3:0] el,
                         output logic em, output logic eie, output int n);
        logic [3:0] len;
        int unsigned avail;
        ei = '0; el = '0; em = 1'b0; eie = 1'b0; n = 0;
        if (pc > 64'd1023) begin
            em = 1'b1;
            return;
        end
        len = len_of(tmem[pc[9:0]][7:4]);
        if (len == 4'd0) begin
            eie = 1'b1;
            el  = 4'd1;
            n   = 1;
        end else begin
            el    = len;
            avail = 1024 - int'(pc[31:0]);
            n     = (int'(len) <= int'(avail)) ? int'(len) : int'(avail);
            em    = (n < int'(len));
        end
        for (int unsigned k = 0; k < n; k++)
            ei = ei | ({72'd0, tmem[pc[9:0] + 10'(k)]} << (72 - 8*k));
    endtask

    task automatic do_fetch(input logic [63:0] pc, input int m, input bit hold, input bit stray_start);
        logic [79:0] ei;
        logic [3:0]  el;
        logic        em, eie;
        int          n, base_idx, cyc, acks, reqs, bad;
        bit          seen;
        mode = m;
        model(pc, ei, el, em, eie, n);
        base_idx   = log_q.size();
        bus.pc     = pc;
        bus.start  = 1'b1;
        stray      = stray_start;
        stray_data = 8'($urandom);
        @(posedge clk);
        #1;
        stray = 1'b0;
        if (!hold) bus.start = 1'b0;
        @(negedge clk);
        cyc  = 1;
        seen = (bus.done === 1'b1);
        check("busy_after_start", bus.busy, 1);
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) seen = 1;
        end
        bus.start = 1'b0;
        check("done_seen", seen, 1);
        check("instr", bus.instr, ei);
        check("ilen", bus.ilen, el);
        check("mem_error", bus.mem_error, em);
        check("instr_error", bus.instr_error, eie);
        if (m == 0) check("latency_zero_wait", cyc, n + 1);
        if (m == 1) check("latency_wait2", cyc, 3*n + 1);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("busy_cleared", bus.busy, 0);
        @(negedge clk);
        check("instr_hold", bus.instr, ei);
        acks = 0; reqs = 0; bad = 0;
        for (int i = base_idx; i < log_q.size(); i++) begin
            if (log_q[i].addr !== pc + 64'(acks)) bad++;
            if (log_q[i].ack) acks++;
            reqs++;
        end
        check("ack_count", acks, n);
        check("addr_sequence", bad, 0);
        if (m == 0) check("req_cycles_zero_wait", reqs, n);
        if (m == 1) check("req_cycles_wait2", reqs, 3*n);
        last_ei = ei;
        last_el = el;
    endtask

    initial begin
        int base_idx, acks, dp0, guard;
        logic [63:0] rpc;
        for (int i = 0; i < 1024; i++) tmem[i] = 8'($urandom);
        bus.start = 1'b0;
        bus.pc    = '0;

        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_ilen", bus.ilen, 0);
        check("rst_mem_error", bus.mem_error, 0);
        check("rst_instr_error", bus.instr_error, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Halt, started on the first edge after reset release
        tmem[0] = 8'h00;
        do_fetch(64'd0, 0, 0, 0);

        // irmovq with two wait cycles per byte
        tmem[16] = 8'h30; tmem[17] = 8'hF3;
        for (int i = 0; i < 8; i++) tmem[18 + i] = 8'(i + 1);
        do_fetch(64'h10, 1, 0, 0);
        check("irmovq_const", bus.instr, 80'h30F3_0102030405060708);
        check("irmovq_ilen", bus.ilen, 4'd10);

        do_fetch(64'd1024, 0, 0, 0);
        check("oor_ilen", bus.ilen, 4'd0);

        tmem[1020] = 8'h30;
        do_fetch(64'd1020, 2, 0, 0);
        check("boundary_mem_error", bus.mem_error, 1);
        check("boundary_low_bytes", bus.instr[47:0], 48'd0);

        tmem[5] = 8'hC0;
        do_fetch(64'd5, 0, 1, 0);
        check("invalid_error", bus.instr_error, 1);

        // Stray acks while idle
        stray = 1'b1;
        stray_data = 8'hA5;
        repeat (2) begin
            @(negedge clk);
            check("stray_busy", bus.busy, 0);
            check("stray_done", bus.done, 0);
        end
        stray = 1'b0;
        @(negedge clk);
        check("stray_instr_hold", bus.instr, last_ei);
        check("stray_ilen_hold", bus.ilen, last_el);

        do_fetch(64'h10, 0, 0, 1);

        // Reset after the third ack of a 10-byte fetch
        tmem[100] = 8'h30;
        mode = 1;
        base_idx = log_q.size();
        bus.pc = 64'd100;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        acks = 0;
        guard = 0;
        while (acks < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
            acks = 0;
            for (int i = base_idx; i < log_q.size(); i++) if (log_q[i].ack) acks++;
        end
        check("third_ack_reached", acks, 3);
        check("req_before_reset", bus.mem_req, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_req", bus.mem_req, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_instr", bus.instr, 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        dp0 = done_pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("late_ack_ignored", bus.busy, 0);
        @(negedge clk);
        check("no_done_after_reset", done_pulses, dp0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(64'd100, 0, 0, 0);

        // Randomized fetches
        repeat (40) begin
            case ($urandom_range(0, 9))
                0:       rpc = {$urandom, $urandom} | 64'h400;
                1, 2:    rpc = 64'($urandom_range(1014, 1023));
                default: rpc = 64'($urandom_range(0, 1023));
            endcase
            if (rpc <= 64'd1023 && $urandom_range(0, 1) == 1)
                tmem[rpc[9:0]] = {4'($urandom_range(0, 11)), 4'($urandom)};
            do_fetch(rpc, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
